// File: rtl/lsu_pkg.sv
// Shared types for the load/store queue: op encoding, FSM states, default entry layout.
// Pure declarations; no latency or flow control of its own.
package lsu_pkg;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  localparam int LSQ_ADDR_W = 8;
  localparam int LSQ_DATA_W = 16;
  localparam int LSQ_REG_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsq_state_t;

  typedef struct packed {
    logic                  op;
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_DATA_W-1:0] data;
    logic [LSQ_REG_W-1:0]  rd;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_fifo_mem.sv
// In-order entry storage with wrapping pointers and occupancy count; head readable combinationally.
// Write lands on the edge; caller must not push when full unless popping in the same cycle.
module lsq_fifo_mem
  import lsu_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = lsq_entry_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  entry_t                 i_push_dat,
  input  logic                   i_pop,
  output entry_t                 o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_empty;

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_empty    = (r_count == '0);
  assign o_empty    = w_empty;
  assign o_full     = (r_count == CNT_FULL);
  assign o_count    = r_count;
  assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/lsq_unit.sv
// Load/store queue: in-order FIFO, each head request held MEM_LATENCY cycles in WAIT then one DONE cycle.
// Enqueue while full is dropped (sticky overflow) unless that cycle is DONE; optional LSQ_STATS_EN adds done counters.
module lsq_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              queue_write_en,
  input  logic              instr_bit,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              instr_bit_out,
  output logic              done_bit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_W-1:0]  rd_out,
  output logic              queue_full,
  output logic              queue_empty,
  output logic              overflow,
`ifdef LSQ_STATS_EN
  output logic [15:0]       ld_done_cnt,
  output logic [15:0]       st_done_cnt,
`endif
  output logic              busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] LAT_ONE    = CNT_W'(1);
  localparam logic [$clog2(DEPTH):0] OCC_ONE = ($clog2(DEPTH)+1)'(1);

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
  } entry_t;

  lsq_state_t             r_state;
  lsq_state_t             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_overflow;
  entry_t                 w_push_dat;
  entry_t                 w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;

  // A DONE cycle pops on the same edge, so a full queue can still take one.
  assign w_pop      = (r_state == ST_DONE);
  assign w_push     = queue_write_en && (!w_full || w_pop);
  assign w_push_dat = {instr_bit, addr_in, data_in, rd_in};

  lsq_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = LAT_RELOAD;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
        else             w_cnt_nxt   = r_cnt - LAT_ONE;
      end
      ST_DONE: begin
        // Occupancy after this edge is count-1+push; nonzero keeps the pipe busy.
        if ((w_count != OCC_ONE) || w_push) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = LAT_RELOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_overflow <= 1'b0;
    else if (queue_write_en && w_full && !w_pop)   r_overflow <= 1'b1;
  end

`ifdef LSQ_STATS_EN
  logic [15:0] r_ld_cnt;
  logic [15:0] r_st_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
    end else if (w_pop) begin
      if (w_head.op == OP_LD && r_ld_cnt != 16'hFFFF) r_ld_cnt <= r_ld_cnt + 16'd1;
      if (w_head.op == OP_ST && r_st_cnt != 16'hFFFF) r_st_cnt <= r_st_cnt + 16'd1;
    end
  end

  assign ld_done_cnt = r_ld_cnt;
  assign st_done_cnt = r_st_cnt;
`endif

  assign done_bit      = w_pop;
  assign instr_bit_out = w_head.op;
  assign mem_addr      = w_head.addr;
  assign mem_wdata     = w_head.data;
  assign rd_out        = w_head.rd;
  assign queue_full    = w_full;
  assign queue_empty   = w_empty;
  assign overflow      = r_overflow;
  assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_lsq_unit.sv
// Directed bench for lsq_unit: instance a uses MEM_LATENCY=2, instance b uses MEM_LATENCY=15.
// Completions are checked against per-instance scoreboards filled when requests are driven.
module tb_lsq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        we_a, op_a;
  logic [7:0]  addr_a;
  logic [15:0] data_a;
  logic [3:0]  rd_a;
  logic        iout_a, done_a, full_a, empty_a, ovf_a, busy_a;
  logic [7:0]  maddr_a;
  logic [15:0] wdat_a;
  logic [3:0]  rdo_a;

  logic        we_b, op_b;
  logic [7:0]  addr_b;
  logic [15:0] data_b;
  logic [3:0]  rd_b;
  logic        iout_b, done_b, full_b, empty_b, ovf_b, busy_b;
  logic [7:0]  maddr_b;
  logic [15:0] wdat_b;
  logic [3:0]  rdo_b;

`ifdef LSQ_STATS_EN
  logic [15:0] ldc_a, stc_a, ldc_b, stc_b;
`endif

  lsq_unit #(.DEPTH(8), .ADDR_W(8), .DATA_W(16), .REG_W(4), .MEM_LATENCY(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .queue_write_en(we_a), .instr_bit(op_a),
    .addr_in(addr_a), .data_in(data_a), .rd_in(rd_a),
    .instr_bit_out(iout_a), .done_bit(done_a), .mem_addr(maddr_a), .mem_wdata(wdat_a),
    .rd_out(rdo_a), .queue_full(full_a), .queue_empty(empty_a), .overflow(ovf_a),
`ifdef LSQ_STATS_EN
    .ld_done_cnt(ldc_a), .st_done_cnt(stc_a),
`endif
    .busy(busy_a)
  );

  lsq_unit #(.DEPTH(8), .ADDR_W(8), .DATA_W(16), .REG_W(4), .MEM_LATENCY(15)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .queue_write_en(we_b), .instr_bit(op_b),
    .addr_in(addr_b), .data_in(data_b), .rd_in(rd_b),
    .instr_bit_out(iout_b), .done_bit(done_b), .mem_addr(maddr_b), .mem_wdata(wdat_b),
    .rd_out(rdo_b), .queue_full(full_b), .queue_empty(empty_b), .overflow(ovf_b),
`ifdef LSQ_STATS_EN
    .ld_done_cnt(ldc_b), .st_done_cnt(stc_b),
`endif
    .busy(busy_b)
  );

  logic [28:0] sb_a[$];
  logic [28:0] sb_b[$];
  int vecs = 0;
  int errs = 0;
  int ndone_a = 0;
  int ndone_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && done_a === 1'b1) begin
      ndone_a++;
      chk("a_done_has_expected", 32'(sb_a.size() != 0), 32'(1));
      if (sb_a.size() != 0) chk("a_head", 32'({iout_a, maddr_a, wdat_a, rdo_a}), 32'(sb_a.pop_front()));
    end
    if (reset_n === 1'b1 && done_b === 1'b1) begin
      ndone_b++;
      chk("b_done_has_expected", 32'(sb_b.size() != 0), 32'(1));
      if (sb_b.size() != 0) chk("b_head", 32'({iout_b, maddr_b, wdat_b, rdo_b}), 32'(sb_b.pop_front()));
    end
  end

  task automatic enq_a(input logic op, input logic [7:0] a, input logic [15:0] d, input logic [3:0] r);
    we_a = 1'b1; op_a = op; addr_a = a; data_a = d; rd_a = r;
    sb_a.push_back({op, a, d, r});
    @(negedge clk);
  endtask

  task automatic enq_b(input logic op, input logic [7:0] a, input logic [15:0] d, input logic [3:0] r,
                       input logic accept);
    we_b = 1'b1; op_b = op; addr_b = a; data_b = d; rd_b = r;
    if (accept) sb_b.push_back({op, a, d, r});
    @(negedge clk);
  endtask

  initial begin
    int nd;
    reset_n = 1'b0;
    we_a = 0; op_a = 0; addr_a = 0; data_a = 0; rd_a = 0;
    we_b = 0; op_b = 0; addr_b = 0; data_b = 0; rd_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_empty", 32'(empty_a), 32'(1));
    chk("rst_full", 32'(full_a), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    reset_n = 1'b1;

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_done", 32'(done_a), 32'(0));
    end
    chk("t1_empty", 32'(empty_a), 32'(1));
    chk("t1_busy", 32'(busy_a), 32'(0));
    chk("t1_head", 32'({iout_a, maddr_a, wdat_a, rdo_a}), 32'(0));
    chk("t1_ovf", 32'(ovf_a), 32'(0));

    // Single LD: enqueue edge is edge 0, done visible after edge 3 (cycle 4)
    enq_a(1'b0, 8'h10, 16'h0000, 4'h3);
    we_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_done", 32'(done_a), 32'(k == 3));
      if (k == 3) chk("t2_head", 32'({iout_a, maddr_a, rdo_a}), 32'({1'b0, 8'h10, 4'h3}));
      @(negedge clk);
    end
    chk("t2_empty", 32'(empty_a), 32'(1));
    chk("t2_busy", 32'(busy_a), 32'(0));
    chk("t2_ndone", 32'(ndone_a), 32'(1));

    // ST then LD back-to-back: done at +3 and +6 from the ST edge
    enq_a(1'b1, 8'h20, 16'hBEEF, 4'h0);
    enq_a(1'b0, 8'h20, 16'h0000, 4'h5);
    we_a = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk("t3_done", 32'(done_a), 32'(k == 3 || k == 6));
      if (k == 3) chk("t3_st_head", 32'({iout_a, wdat_a}), 32'({1'b1, 16'hBEEF}));
      if (k == 6) chk("t3_ld_head", 32'({iout_a, maddr_a, rdo_a}), 32'({1'b0, 8'h20, 4'h5}));
      @(negedge clk);
    end
    chk("t3_empty", 32'(empty_a), 32'(1));

    // Nine enqueues into the slow instance: eighth fills, ninth drops
    for (int i = 0; i < 9; i++) begin
      enq_b(1'b0, 8'(8'h40 + i), 16'(i), 4'(i), i < 8);
      if (i == 7) begin
        chk("t4_full8", 32'(full_b), 32'(1));
        chk("t4_ovf_before", 32'(ovf_b), 32'(0));
      end
    end
    we_b = 1'b0;
    chk("t4_ovf_set", 32'(ovf_b), 32'(1));
    chk("t4_head_first", 32'(maddr_b), 32'(8'h40));
    for (int k = 0; k < 300 && !(empty_b && !busy_b); k++) @(negedge clk);
    chk("t4_drained", 32'(empty_b && !busy_b), 32'(1));
    chk("t4_ndone", 32'(ndone_b), 32'(8));
    chk("t4_ovf_sticky", 32'(ovf_b), 32'(1));

    // Refill, then enqueue during the DONE cycle of a full queue
    for (int i = 0; i < 8; i++) enq_b(1'b1, 8'(8'h80 + i), 16'(16'hA000 + i), 4'(i), 1'b1);
    we_b = 1'b0;
    chk("t5_full", 32'(full_b), 32'(1));
    for (int k = 0; k < 40 && done_b !== 1'b1; k++) @(negedge clk);
    chk("t5_done_seen", 32'(done_b), 32'(1));
    enq_b(1'b0, 8'hC0, 16'h1234, 4'hA, 1'b1);
    we_b = 1'b0;
    chk("t5_still_full", 32'(full_b), 32'(1));
    chk("t5_ovf_unchanged", 32'(ovf_b), 32'(1));
    chk("t5_done_one_cycle", 32'(done_b), 32'(0));
    for (int k = 0; k < 300 && !(empty_b && !busy_b); k++) @(negedge clk);
    chk("t5_ndone", 32'(ndone_b), 32'(17));
    chk("t5_sb_empty", 32'(sb_b.size()), 32'(0));

    // Reset mid-WAIT with three queued
    enq_a(1'b0, 8'h01, 16'h0001, 4'h1);
    enq_a(1'b1, 8'h02, 16'h0002, 4'h2);
    enq_a(1'b0, 8'h03, 16'h0003, 4'h3);
    we_a = 1'b0;
    chk("t6_busy_pre", 32'(busy_a), 32'(1));
    reset_n = 1'b0;
    sb_a.delete();
    #1;
    chk("t6_empty", 32'(empty_a), 32'(1));
    chk("t6_busy", 32'(busy_a), 32'(0));
    chk("t6_done", 32'(done_a), 32'(0));
    chk("t6_head", 32'({iout_a, maddr_a, wdat_a, rdo_a}), 32'(0));
    nd = ndone_a;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_no_done", 32'(ndone_a), 32'(nd));
    chk("t6_empty_after", 32'(empty_a), 32'(1));
`ifdef LSQ_STATS_EN
    chk("t6_ld_cnt_rst", 32'(ldc_a), 32'(0));
    chk("t6_st_cnt_rst", 32'(stc_a), 32'(0));
`endif

    enq_a(1'b0, 8'h31, 16'h0000, 4'h7);
    enq_a(1'b1, 8'h32, 16'hCAFE, 4'h0);
    enq_a(1'b0, 8'h33, 16'h0000, 4'h9);
    we_a = 1'b0;
    for (int k = 0; k < 50 && !(empty_a && !busy_a); k++) @(negedge clk);
    chk("t6_ndone3", 32'(ndone_a), 32'(nd + 3));
    chk("t6_sb_empty", 32'(sb_a.size()), 32'(0));
`ifdef LSQ_STATS_EN
    chk("t6_ld_cnt", 32'(ldc_a), 32'(2));
    chk("t6_st_cnt", 32'(stc_a), 32'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lsq_unit.md
Name: lsq_unit

Overview:
Load/store queue sitting between the Controller and data memory in each compute unit. It accepts LD/ST requests when the Controller asserts queue_write_en, holds them in an in-order FIFO, and times each one against a fixed memory latency. It then signals completion back to the Controller via done_bit/instr_bit_out, which the Controller decodes into mem_read_en/mem_write_en/reg_write_en. Address, store data and destination register of the head entry drive data memory and the thread register file directly.

Parameters:
DEPTH, 8, queue entries; power of 2, ≥2
ADDR_W, 8, data-memory address width
DATA_W, 16, store data width
REG_W, 4, destination register index width
MEM_LATENCY, 2, cycles spent in WAIT per request; ≥1

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
queue_write_en  in  1  enqueue strobe from Controller
instr_bit  in  1  op of incoming request from Controller: 0=LD, 1=ST
addr_in  in  ADDR_W  request address
data_in  in  DATA_W  store data; ignored for LD
rd_in  in  REG_W  LD destination register
instr_bit_out  out  1  op of head entry, to Controller instr_bit_in
done_bit  out  1  head request complete this cycle, to Controller
mem_addr  out  ADDR_W  head address to data memory
mem_wdata  out  DATA_W  head store data to data memory
rd_out  out  REG_W  head destination register to register file
queue_full  out  1  count==DEPTH
queue_empty  out  1  count==0
overflow  out  1  sticky: an enqueue was dropped
busy  out  1  state!=IDLE or !queue_empty

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, rd_ptr=wr_ptr=0, count=0, latency counter=0, overflow=0. Outputs: done_bit=0, queue_empty=1, queue_full=0, busy=0. instr_bit_out, mem_addr, mem_wdata and rd_out are 0 while empty. Entry storage is not reset.
- Enqueue: when queue_write_en=1 and the queue is not full, {instr_bit, addr_in, data_in, rd_in} is written at wr_ptr on the edge, and wr_ptr advances modulo DEPTH (wrap-around).
- Full queue: an enqueue with queue_write_en=1 and count==DEPTH is dropped and sets overflow; overflow clears only on reset.
  - Exception: an enqueue in a DONE cycle while full is accepted, because the pop frees a slot in the same edge.
- Head outputs: instr_bit_out, mem_addr, mem_wdata and rd_out are driven combinationally from entry[rd_ptr] when non-empty, otherwise 0.
- FSM, Moore outputs:
  - IDLE: if !queue_empty, go to WAIT and load cnt=MEM_LATENCY-1.
  - WAIT: if cnt==0, go to DONE; else decrement cnt.
  - DONE: done_bit=1 for exactly this cycle. Pop on the edge (rd_ptr++ mod DEPTH). If the count after pop and push is >0, go to WAIT with cnt reloaded; else go to IDLE.
- Latency: a request enqueued on edge 0 into an empty, idle queue gives done_bit=1 in cycle 2+MEM_LATENCY. Back-to-back throughput is one request per MEM_LATENCY+1 cycles.
- Ordering: strictly in order; no reordering or bypass between LD and ST.
- Count arithmetic:
  - simultaneous push and pop: count unchanged
  - push only: +1
  - pop only: -1
  - count is ($clog2(DEPTH)+1) bits wide
- Reset mid-operation: all in-flight and queued requests are discarded; no done_bit is emitted for them.

Optional Feature:
LSQ_STATS_EN
- Defined: adds outputs ld_done_cnt[15:0] and st_done_cnt[15:0], both reset to 0. In each DONE cycle the counter selected by instr_bit_out increments, saturating at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg:
  - OP_LD=1'b0, OP_ST=1'b1
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2
  - packed entry typedef lsq_entry_t {op, addr, data, rd}
- Sub-module lsq_fifo_mem: storage array plus pointers, count, full/empty. The FSM, latency counter and overflow stay in lsq_unit.

Test Plan:
1. Reset, then hold idle 5 cycles -> done_bit=0, queue_empty=1, busy=0, head outputs 0.
2. MEM_LATENCY=2, enqueue LD addr=8'h10 rd=4'h3 on edge 0 -> done_bit=1 only in cycle 4, with instr_bit_out=0, mem_addr=8'h10, rd_out=3; queue_empty=1 in cycle 5.
3. Enqueue ST(addr 8'h20, data 16'hBEEF) then LD(addr 8'h20) back-to-back -> ST completes first with instr_bit_out=1, mem_wdata=16'hBEEF; LD done_bit follows exactly 3 cycles later.
4. Enqueue 9 requests with no completions possible (MEM_LATENCY=15) -> queue_full=1 after 8, 9th dropped, overflow=1 and stays 1; exactly 8 done pulses are observed.
5. Full queue, enqueue during the DONE cycle -> accepted, count stays 8, overflow unchanged.
6. Assert reset_n=0 mid-WAIT with 3 entries queued -> immediate IDLE/empty, no done_bit after release. With LSQ_STATS_EN: 2 LDs + 1 ST completed -> ld_done_cnt=2, st_done_cnt=1.
